// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//
// Issue-stage controller sitting between the instruction decoder and the
// execution units. It keeps one decoded instruction in an issue register,
// tracks outstanding register writebacks in a busy vector and stalls the
// decoder on RAW/WAW hazards. Serialising instructions (CSR, ecall, ebreak,
// mret, sret) only issue into an empty pipeline, and they block all further
// issue until execute reports that they have completed.
//
// Optional feature macro: SCOREBOARD_BYPASS_EN
//   When defined, a writeback retiring in the current cycle is already treated
//   as not busy by the hazard check and by the DRAIN exit test. A dependent
//   instruction can then transfer in the same cycle its producer writes back.
//   When undefined, only the registered busy vector is consulted.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dec_*             decoder side: valid/ready handshake, source and
//                     destination register info, serialise flag, payload
//   iss_*             execute side: issue register valid/ready, payload and
//                     registered destination register info
//   wbk_valid_i/adr_i retiring writeback, clears the matching busy bit
//   serial_done_i     the serialised instruction has completed
//   flush_i           pipeline flush, highest priority after reset
//   busy_o            current busy vector (bit 0 is always 0)
//   state_o           FSM state: 00 RUN, 01 DRAIN, 10 SERIAL
// ---------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int NB_REGS   = 32,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic                 dec_rs1_v_i,
  input  logic [4:0]           dec_rs1_adr_i,
  input  logic                 dec_rs2_v_i,
  input  logic [4:0]           dec_rs2_adr_i,
  input  logic                 dec_wbk_v_i,
  input  logic [4:0]           dec_wbk_adr_i,
  input  logic                 dec_serialize_i,
  input  logic [PAYLOAD_W-1:0] dec_payload_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [PAYLOAD_W-1:0] iss_payload_o,
  output logic                 iss_wbk_v_o,
  output logic [4:0]           iss_wbk_adr_o,
  input  logic                 wbk_valid_i,
  input  logic [4:0]           wbk_adr_i,
  input  logic                 serial_done_i,
  input  logic                 flush_i,
  output logic [NB_REGS-1:0]   busy_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    SERIAL = 2'b10
  } state_t;

  state_t               state_q;
  logic [NB_REGS-1:0]   busy_q;
  logic [NB_REGS-1:0]   busy_chk;
  logic [NB_REGS-1:0]   busy_n;
  logic [NB_REGS-1:0]   clear_mask;
  logic [NB_REGS-1:0]   set_mask;
  logic                 iss_valid_q;
  logic [PAYLOAD_W-1:0] iss_payload_q;
  logic                 iss_wbk_v_q;
  logic [4:0]           iss_wbk_adr_q;

  logic rs1_hit;
  logic rs2_hit;
  logic rd_hit;
  logic hazard;
  logic pipe_empty;
  logic drain_empty;
  logic slot_free;
  logic serial_block;
  logic dec_ready;
  logic transfer;
  logic drain;

  // One-hot of the retiring writeback register.
  always_comb begin
    clear_mask = '0;
    if (wbk_valid_i) begin
      clear_mask[wbk_adr_i] = 1'b1;
    end
  end

  // Busy view used for hazard detection and the DRAIN exit test.
`ifdef SCOREBOARD_BYPASS_EN
  assign busy_chk = busy_q & ~clear_mask;
`else
  assign busy_chk = busy_q;
`endif

  // Register 0 is hardwired, so it never participates in hazards.
  assign rs1_hit = dec_rs1_v_i & (dec_rs1_adr_i != 5'd0) & busy_chk[dec_rs1_adr_i];
  assign rs2_hit = dec_rs2_v_i & (dec_rs2_adr_i != 5'd0) & busy_chk[dec_rs2_adr_i];
  assign rd_hit  = dec_wbk_v_i & (dec_wbk_adr_i != 5'd0) & busy_chk[dec_wbk_adr_i];
  assign hazard  = rs1_hit | rs2_hit | rd_hit;

  // RUN decides DRAIN vs. direct serial issue on the registered state, while
  // DRAIN may leave one cycle early when the bypass is enabled.
  assign pipe_empty   = (busy_q == '0) & ~iss_valid_q;
  assign drain_empty  = (busy_chk == '0) & ~iss_valid_q;
  assign slot_free    = ~iss_valid_q | iss_ready_i;
  assign serial_block = dec_serialize_i & ~pipe_empty;

  assign dec_ready = (state_q == RUN) & ~reset & ~flush_i & ~hazard
                   & slot_free & ~serial_block;
  assign transfer  = dec_valid_i & dec_ready;
  assign drain     = iss_valid_q & iss_ready_i;

  // Next busy vector: retire first, then set, so a same-cycle set wins.
  always_comb begin
    set_mask = '0;
    if (transfer && dec_wbk_v_i && (dec_wbk_adr_i != 5'd0)) begin
      set_mask[dec_wbk_adr_i] = 1'b1;
    end
    busy_n    = (busy_q & ~clear_mask) | set_mask;
    busy_n[0] = 1'b0;
  end

  // Issue register, busy vector and serialisation FSM. A flush clears all
  // in-flight tracking but keeps the stale payload; reset also zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      busy_q        <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_wbk_v_q   <= 1'b0;
      iss_wbk_adr_q <= 5'd0;
    end else if (flush_i) begin
      state_q     <= RUN;
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_wbk_v_q <= 1'b0;
    end else begin
      busy_q <= busy_n;

      if (transfer) begin
        iss_valid_q   <= 1'b1;
        iss_payload_q <= dec_payload_i;
        iss_wbk_v_q   <= dec_wbk_v_i;
        iss_wbk_adr_q <= dec_wbk_adr_i;
      end else if (drain) begin
        iss_valid_q <= 1'b0;
      end

      case (state_q)
        RUN: begin
          if (dec_valid_i && dec_serialize_i && !pipe_empty) begin
            state_q <= DRAIN;
          end else if (transfer && dec_serialize_i) begin
            state_q <= SERIAL;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state_q <= RUN;
          end
        end
        SERIAL: begin
          if (serial_done_i) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign dec_ready_o   = dec_ready;
  assign iss_valid_o   = iss_valid_q;
  assign iss_payload_o = iss_payload_q;
  assign iss_wbk_v_o   = iss_wbk_v_q;
  assign iss_wbk_adr_o = iss_wbk_adr_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;

endmodule
